// File: rtl/ulpb_tx_queue.sv
// Transmit message queue in front of the ULPB bus node: buffers {addr, data}
// messages and presents them one at a time over the REQ_TX/ACK_TX 4-phase handshake.
module ulpb_tx_queue #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [ADDR_WIDTH-1:0]       WR_ADDR,
  input  logic [DATA_WIDTH-1:0]       WR_DATA,
  input  logic                        WR_EN,
  input  logic                        FLUSH,
  output logic                        FULL,
  output logic                        EMPTY,
  output logic [$clog2(DEPTH):0]      COUNT,
  output logic                        OVERFLOW,
  output logic [ADDR_WIDTH-1:0]       ADDR_IN,
  output logic [DATA_WIDTH-1:0]       DATA_IN,
  output logic                        REQ_TX,
  input  logic                        ACK_TX,
  output logic                        BUSY,
  output logic                        TX_SENT
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_req;
  logic                  r_sent;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_launch;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // FULL is from the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_push   = WR_EN & ~w_full & ~FLUSH;
  // A stale ACK_TX or a FLUSH both hold off the launch.
  assign w_launch = (r_state == StIdle) & ~w_empty & ~ACK_TX & ~FLUSH;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= WR_ADDR;
      r_mem_data[r_tail] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= StIdle;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_req      <= 1'b0;
      r_sent     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_sent <= 1'b0;

      if (FLUSH) begin
        r_head     <= r_tail;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_launch) r_head <= r_head + PW'(1);
        if (WR_EN && w_full) r_overflow <= 1'b1;
        if (w_push && !w_launch) begin
          r_count <= r_count + CW'(1);
        end else if (w_launch && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end

      case (r_state)
        StIdle: begin
          if (w_launch) begin
            r_state <= StReq;
            r_req   <= 1'b1;
            r_addr  <= r_mem_addr[r_head];
            r_data  <= r_mem_data[r_head];
          end
        end
        StReq: begin
          if (ACK_TX) begin
            r_state <= StRelease;
            r_req   <= 1'b0;
            r_sent  <= 1'b1;
          end
        end
        StRelease: begin
          if (!ACK_TX) r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign COUNT    = r_count;
  assign OVERFLOW = r_overflow;
  assign ADDR_IN  = r_addr;
  assign DATA_IN  = r_data;
  assign REQ_TX   = r_req;
  assign BUSY     = (r_state != StIdle);
  assign TX_SENT  = r_sent;

endmodule

// File: tb/tb_ulpb_tx_queue.sv
// Bench for ulpb_tx_queue: a per-cycle vector table for the single-message and
// fill/overflow flows, then hand-written wrap, push+pop, flush and reset sequences.
module tb_ulpb_tx_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        full, empty, ovf, req, busy, sent;
  logic [2:0]  count;
  logic [7:0]  addr_in;
  logic [31:0] data_in;

  int tests = 0;
  int fails = 0;
  int sent_cnt = 0;

  ulpb_tx_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK(clk), .RESET(rst), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_EN(wr_en),
    .FLUSH(flush), .FULL(full), .EMPTY(empty), .COUNT(count), .OVERFLOW(ovf),
    .ADDR_IN(addr_in), .DATA_IN(data_in), .REQ_TX(req), .ACK_TX(ack), .BUSY(busy),
    .TX_SENT(sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sent) sent_cnt <= sent_cnt + 1;

  typedef struct {
    logic rst, we;
    logic [7:0] a;
    logic [31:0] d;
    logic fl, ak;
    logic er, es, eb;
    logic [2:0] ec;
    logic ef, ee, eo;
    logic [7:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic we, logic [7:0] a, logic [31:0] d, logic fl,
                              logic ak, logic er, logic es, logic eb, logic [2:0] ec,
                              logic ef, logic ee, logic eo, logic [7:0] ea, logic [31:0] ed);
    vec_t v;
    v.rst = r;  v.we = we; v.a = a;   v.d = d;   v.fl = fl; v.ak = ak;
    v.er = er;  v.es = es; v.eb = eb; v.ec = ec; v.ef = ef; v.ee = ee;
    v.eo = eo;  v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Node-side responder: wait for a request, check it, ACK after a delay, release.
  task automatic serve(input string nm, input logic [7:0] ea, input logic [31:0] ed,
                       input int delay);
    int t = 0;
    while (!req && t < 100) begin
      tick();
      t++;
    end
    chk({nm, ".req_seen"}, 64'(req), 64'd1);
    if (req) begin
      chk({nm, ".addr"}, 64'(addr_in), 64'(ea));
      chk({nm, ".data"}, 64'(data_in), 64'(ed));
      repeat (delay) tick();
      chk({nm, ".req_held"}, 64'(req), 64'd1);
      ack = 1'b1;
      tick();
      chk({nm, ".sent"}, 64'(sent), 64'd1);
      chk({nm, ".req_drop"}, 64'(req), 64'd0);
      ack = 1'b0;
      tick();
      chk({nm, ".idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int seen;

    //                rst we  addr   data          fl ak  req snt bsy cnt full emp ovf ain   din
    vecs.push_back(mk(1, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd0, 0, 1, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 1, 8'hab, 32'h12345678,  0, 0,  0, 0, 0, 3'd1, 0, 0, 0, 8'h00, 32'h0));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 0, 1, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd0, 0, 1, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 1, 8'h01, 32'h11,        0, 0,  0, 0, 0, 3'd1, 0, 0, 0, 8'hab, 32'h12345678));
    vecs.push_back(mk(0, 1, 8'h02, 32'h12,        0, 0,  1, 0, 1, 3'd1, 0, 0, 0, 8'h01, 32'h11));
    vecs.push_back(mk(0, 1, 8'h03, 32'h13,        0, 0,  1, 0, 1, 3'd2, 0, 0, 0, 8'h01, 32'h11));
    vecs.push_back(mk(0, 1, 8'h04, 32'h14,        0, 0,  1, 0, 1, 3'd3, 0, 0, 0, 8'h01, 32'h11));
    vecs.push_back(mk(0, 1, 8'h05, 32'h15,        0, 0,  1, 0, 1, 3'd4, 1, 0, 0, 8'h01, 32'h11));
    vecs.push_back(mk(0, 1, 8'h06, 32'h16,        0, 0,  1, 0, 1, 3'd4, 1, 0, 1, 8'h01, 32'h11));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd4, 1, 0, 1, 8'h01, 32'h11));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd4, 1, 0, 1, 8'h01, 32'h11));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd3, 0, 0, 1, 8'h02, 32'h12));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd3, 0, 0, 1, 8'h02, 32'h12));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd3, 0, 0, 1, 8'h02, 32'h12));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd2, 0, 0, 1, 8'h03, 32'h13));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd2, 0, 0, 1, 8'h03, 32'h13));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd2, 0, 0, 1, 8'h03, 32'h13));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd1, 0, 0, 1, 8'h04, 32'h14));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd1, 0, 0, 1, 8'h04, 32'h14));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd1, 0, 0, 1, 8'h04, 32'h14));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  1, 0, 1, 3'd0, 0, 1, 1, 8'h05, 32'h15));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 1,  0, 1, 1, 3'd0, 0, 1, 1, 8'h05, 32'h15));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd0, 0, 1, 1, 8'h05, 32'h15));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         0, 0,  0, 0, 0, 3'd0, 0, 1, 1, 8'h05, 32'h15));
    vecs.push_back(mk(0, 0, 8'h00, 32'h0,         1, 0,  0, 0, 0, 3'd0, 0, 1, 0, 8'h05, 32'h15));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].a; wr_data = vecs[i].d;
      flush = vecs[i].fl; ack = vecs[i].ak;
      tick();
      chk($sformatf("v%0d.req", i),   64'(req),     64'(vecs[i].er));
      chk($sformatf("v%0d.sent", i),  64'(sent),    64'(vecs[i].es));
      chk($sformatf("v%0d.busy", i),  64'(busy),    64'(vecs[i].eb));
      chk($sformatf("v%0d.count", i), 64'(count),   64'(vecs[i].ec));
      chk($sformatf("v%0d.full", i),  64'(full),    64'(vecs[i].ef));
      chk($sformatf("v%0d.empty", i), 64'(empty),   64'(vecs[i].ee));
      chk($sformatf("v%0d.ovf", i),   64'(ovf),     64'(vecs[i].eo));
      chk($sformatf("v%0d.addr", i),  64'(addr_in), 64'(vecs[i].ea));
      chk($sformatf("v%0d.data", i),  64'(data_in), 64'(vecs[i].ed));
    end
    rst = 1'b0; wr_en = 1'b0; flush = 1'b0; ack = 1'b0;

    // Wrap: ten messages through a four-entry queue, producer respecting FULL.
    do_reset();
    base = sent_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int t = 0;
          while (full && t < 100) begin
            tick();
            t++;
          end
          push(8'(i), 32'(i));
        end
      end
      begin
        for (int k = 0; k < 10; k++) serve($sformatf("wrap%0d", k), 8'(k), 32'(k), 2);
      end
    join
    tick();
    chk("wrap.sent_pulses", 64'(sent_cnt - base), 64'd10);
    chk("wrap.empty", 64'(empty), 64'd1);
    chk("wrap.ovf", 64'(ovf), 64'd0);

    // Stale ACK blocks launch; then push on the launch cycle keeps COUNT.
    do_reset();
    ack = 1'b1;
    push(8'ha1, 32'ha1);
    push(8'ha2, 32'ha2);
    chk("stale.req", 64'(req), 64'd0);
    chk("stale.count", 64'(count), 64'd2);
    tick();
    chk("stale.req_hold", 64'(req), 64'd0);
    ack = 1'b0;
    push(8'ha3, 32'ha3);
    chk("pushpop.count", 64'(count), 64'd2);
    chk("pushpop.req", 64'(req), 64'd1);
    serve("pp0", 8'ha1, 32'ha1, 1);
    serve("pp1", 8'ha2, 32'ha2, 1);
    serve("pp2", 8'ha3, 32'ha3, 1);
    chk("pushpop.empty", 64'(empty), 64'd1);

    // FLUSH mid-handshake, with a same-cycle write and a pending overflow.
    do_reset();
    for (int i = 0; i < 6; i++) push(8'(8'hc0 + i), 32'(32'hc0 + i));
    chk("flush.pre_count", 64'(count), 64'd4);
    chk("flush.pre_ovf", 64'(ovf), 64'd1);
    flush = 1'b1; wr_en = 1'b1; wr_addr = 8'hee; wr_data = 32'hee;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.ovf", 64'(ovf), 64'd0);
    chk("flush.req", 64'(req), 64'd1);
    serve("flush_inflight", 8'hc0, 32'hc0, 2);
    seen = 0;
    repeat (8) begin
      tick();
      if (req) seen++;
    end
    chk("flush.no_more_req", 64'(seen), 64'd0);
    push(8'hd0, 32'hd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_launch.req", 64'(req), 64'd0);
    chk("flush_launch.count", 64'(count), 64'd0);
    tick();
    chk("flush_launch.req2", 64'(req), 64'd0);

    // Reset during REQ drops the request and discards queued entries.
    do_reset();
    push(8'hf1, 32'hf1);
    push(8'hf2, 32'hf2);
    chk("rst.pre_req", 64'(req), 64'd1);
    chk("rst.pre_count", 64'(count), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.req", 64'(req), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.addr", 64'(addr_in), 64'd0);
    tick();
    chk("rst.req_after", 64'(req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
